cdb_arbiter: RTL and testbench

Producer side of the common data bus (CDB): collects completed results (tag + value) from up to `N_SRC` functional units and broadcasts exactly one per cycle to the register status table and reservation stations. It drives the `CDB_broadcast` / `CDB_tag` / `CDB_val` triple those blocks consume. Each source has a one-entry holding buffer, and the buffers are drained by a round-robin arbiter.

---
 rtl/cdb_arbiter.sv | 107 ++++++++++
 tb/tb_cdb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : One-entry holding buffer per functional unit, round-robin drained
//            onto the common data bus one result per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_SRC  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          in_valid,
  input  logic [N_SRC*TAG_W-1:0]    in_tag,
  input  logic [N_SRC*DATA_W-1:0]   in_val,
  output logic [N_SRC-1:0]          out_ready,
  output logic                      out_CDB_broadcast,
  output logic [TAG_W-1:0]          out_CDB_tag,
  output logic [DATA_W-1:0]         out_CDB_val,
  output logic                      out_busy,
  output logic                      out_err
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(N_SRC - 1);

  logic [N_SRC-1:0]  r_full;
  logic [TAG_W-1:0]  r_tag [N_SRC];
  logic [DATA_W-1:0] r_val [N_SRC];
  logic [PTR_W-1:0]  r_ptr;
  logic              r_bcast;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_val;
  logic              r_err;

  logic              w_gvld;
  logic [PTR_W-1:0]  w_gidx;
  logic [N_SRC-1:0]  w_grant;
  logic [N_SRC-1:0]  w_ready;
  logic [PTR_W-1:0]  w_ptr_nxt;

  // Scan from the farthest offset down so the nearest full buffer to r_ptr wins.
  always_comb begin
    int j;
    j       = 0;
    w_gvld  = 1'b0;
    w_gidx  = '0;
    w_grant = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = (int'(r_ptr) + k) % N_SRC;
      if (r_full[j]) begin
        w_gvld = 1'b1;
        w_gidx = PTR_W'(j);
      end
    end
    if (w_gvld) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign w_ready   = rst ? '0 : (~r_full | w_grant);
  assign w_ptr_nxt = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_ptr     <= '0;
      r_bcast   <= 1'b0;
      r_cdb_tag <= '0;
      r_cdb_val <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_gvld) begin
        r_bcast        <= 1'b1;
        r_cdb_tag      <= r_tag[w_gidx];
        r_cdb_val      <= r_val[w_gidx];
        r_full[w_gidx] <= 1'b0;
        r_ptr          <= w_ptr_nxt;
      end else begin
        r_bcast <= 1'b0;
      end
      // A reload here overrides the drain clear above for the same source.
      for (int i = 0; i < N_SRC; i++) begin
        if (in_valid[i] && w_ready[i]) begin
          if (in_tag[i*TAG_W +: TAG_W] != '0) begin
            r_full[i] <= 1'b1;
            r_tag[i]  <= in_tag[i*TAG_W +: TAG_W];
            r_val[i]  <= in_val[i*DATA_W +: DATA_W];
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign out_ready         = w_ready;
  assign out_CDB_broadcast = r_bcast;
  assign out_CDB_tag       = r_cdb_tag;
  assign out_CDB_val       = r_cdb_val;
  assign out_busy          = |r_full;
  assign out_err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*TW-1:0] in_tag;
  logic [N*DW-1:0] in_val;
  logic [N-1:0]    out_ready;
  logic            out_CDB_broadcast;
  logic [TW-1:0]   out_CDB_tag;
  logic [DW-1:0]   out_CDB_val;
  logic            out_busy;
  logic            out_err;

  int n_checks;
  int n_errors;

  cdb_arbiter #(.N_SRC(N), .TAG_W(TW), .DATA_W(DW)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_tag            (in_tag),
    .in_val            (in_val),
    .out_ready         (out_ready),
    .out_CDB_broadcast (out_CDB_broadcast),
    .out_CDB_tag       (out_CDB_tag),
    .out_CDB_val       (out_CDB_val),
    .out_busy          (out_busy),
    .out_err           (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int i, input int tag, input int val);
    in_valid[i]          = 1'b1;
    in_tag[i*TW +: TW]   = TW'(tag);
    in_val[i*DW +: DW]   = DW'(val);
  endtask

  task automatic idle();
    in_valid = '0;
    in_tag   = '0;
    in_val   = '0;
  endtask

  task automatic expect_bc(input string name, input int tag, input int val);
    check({name, "_bc"},  64'(out_CDB_broadcast), 64'd1);
    check({name, "_tag"}, 64'(out_CDB_tag), 64'(tag));
    check({name, "_val"}, 64'(out_CDB_val), 64'(val));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();

    // Reset and single result
    step(); step();
    check("rst_bc",    64'(out_CDB_broadcast), 64'd0);
    check("rst_tag",   64'(out_CDB_tag), 64'd0);
    check("rst_val",   64'(out_CDB_val), 64'd0);
    check("rst_err",   64'(out_err), 64'd0);
    check("rst_busy",  64'(out_busy), 64'd0);
    check("rst_ready", 64'(out_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_idle", 64'(out_ready), 64'hF);
    offer(2, 5, 7);
    step();
    idle();
    check("single_busy1", 64'(out_busy), 64'd1);
    check("single_nobc1", 64'(out_CDB_broadcast), 64'd0);
    step();
    expect_bc("single", 5, 7);
    check("single_busy0", 64'(out_busy), 64'd0);
    step();
    check("single_pulse", 64'(out_CDB_broadcast), 64'd0);

    // Round-robin contention from pointer 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) offer(i, i + 1, (i + 1) * 10);
    step();
    idle();
    check("rr_ready0", 64'(out_ready), 64'b0001);
    check("rr_nobc",   64'(out_CDB_broadcast), 64'd0);
    step();
    expect_bc("rr1", 1, 10);
    check("rr_ready1", 64'(out_ready), 64'b0011);
    step();
    expect_bc("rr2", 2, 20);
    check("rr_ready2", 64'(out_ready), 64'b0111);
    step();
    expect_bc("rr3", 3, 30);
    check("rr_ready3", 64'(out_ready), 64'b1111);
    step();
    expect_bc("rr4", 4, 40);
    check("rr_busy", 64'(out_busy), 64'd0);

    // Pointer wrapped to 0 after granting source 3
    offer(0, 6, 60);
    offer(3, 7, 70);
    step();
    idle();
    check("wrap_nobc", 64'(out_CDB_broadcast), 64'd0);
    step();
    expect_bc("wrap_s0", 6, 60);
    step();
    expect_bc("wrap_s3", 7, 70);
    step();
    check("wrap_end", 64'(out_CDB_broadcast), 64'd0);

    // Back-to-back streaming from source 1
    for (int k = 0; k < 5; k++) begin
      offer(1, k + 1, 100 + k);
      check($sformatf("str_ready%0d", k), 64'(out_ready[1]), 64'd1);
      step();
      if (k > 0) expect_bc($sformatf("str%0d", k), k, 100 + k - 1);
    end
    idle();
    step();
    expect_bc("str5", 5, 104);
    step();
    check("str_end", 64'(out_CDB_broadcast), 64'd0);

    // Tag 0 is discarded and flags an error
    offer(0, 0, 99);
    step();
    idle();
    check("t0_err",  64'(out_err), 64'd1);
    check("t0_busy", 64'(out_busy), 64'd0);
    step();
    check("t0_nobc", 64'(out_CDB_broadcast), 64'd0);
    step();
    check("t0_sticky", 64'(out_err), 64'd1);

    // Reset mid-operation with three buffers full
    offer(0, 8, 80);
    offer(1, 9, 90);
    offer(2, 10, 100);
    step();
    idle();
    check("mid_busy", 64'(out_busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_ready_rst", 64'(out_ready), 64'd0);
    step();
    rst = 1'b0;
    check("mid_nobc0", 64'(out_CDB_broadcast), 64'd0);
    check("mid_busy0", 64'(out_busy), 64'd0);
    check("mid_err0",  64'(out_err), 64'd0);
    step();
    check("mid_nobc1", 64'(out_CDB_broadcast), 64'd0);
    // Pointer back at 0: source 1 must win over source 3
    offer(1, 11, 110);
    offer(3, 12, 120);
    step();
    idle();
    check("post_busy", 64'(out_busy), 64'd1);
    step();
    expect_bc("post_s1", 11, 110);
    step();
    expect_bc("post_s3", 12, 120);
    step();
    check("post_end", 64'(out_CDB_broadcast), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
